rom_loader: RTL and testbench

- Byte-stream boot loader that fills the SoC instruction ROM before the core runs.
- Receives a framed byte stream over a valid/ready interface, assembles little-endian 32-bit words and drives the ROM write port.
- Holds the core in reset (core_hold) until the image is fully written, replacing the simulation-only memory preload on real hardware.
- Sits between a byte source (UART RX or debug port) and the rom write port of riscv_soc.

---
 rtl/rom_loader_if.sv | 30 +++
 rtl/rom_loader.sv | 139 +++++++++++++
 tb/tb_rom_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_loader_if.sv
// Byte-stream input and ROM write port of the boot loader.
// The master modport is the loader; the slave modport is the byte source / ROM side.
interface rom_loader_if #(
   parameter int ADDR_W = 12
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              rom_we;
   logic [ADDR_W-1:0] rom_addr;
   logic [31:0]       rom_wdata;

   modport master (
      input  in_valid,
      input  in_data,
      output in_ready,
      output rom_we,
      output rom_addr,
      output rom_wdata
   );

   modport slave (
      output in_valid,
      output in_data,
      input  in_ready,
      input  rom_we,
      input  rom_addr,
      input  rom_wdata
   );
endinterface

// File: rtl/rom_loader.sv
// Boot loader: parses a length-prefixed little-endian byte stream into ROM word writes
// and holds the core in reset until the whole image has been committed.
module rom_loader #(
   parameter int ADDR_W    = 12,
   parameter int MAX_WORDS = 4096
) (
   input  logic         clk,
   input  logic         rst,
   rom_loader_if.master bus,
   input  logic         reload,
   output logic         load_busy,
   output logic         load_done,
   output logic         load_err,
   output logic         core_hold
);

   typedef enum logic [2:0] {
      ST_HDR,
      ST_DATA,
      ST_FLUSH,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

   state_t            state_q,     state_d;
   logic [1:0]        byte_cnt_q,  byte_cnt_d;
   logic [ADDR_W-1:0] word_idx_q,  word_idx_d;
   logic [ADDR_W-1:0] last_idx_q,  last_idx_d;
   logic [23:0]       shift_q,     shift_d;
   logic              rom_we_q,    rom_we_d;
   logic [ADDR_W-1:0] rom_addr_q,  rom_addr_d;
   logic [31:0]       rom_wdata_q, rom_wdata_d;

   logic        in_ready;
   logic        accept;
   logic [31:0] word;

   assign in_ready = (state_q == ST_HDR) || (state_q == ST_DATA);
   assign accept   = bus.in_valid && in_ready;
   // Header and data words share one shift register; the 4th byte completes the word.
   assign word     = {bus.in_data, shift_q};

   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      word_idx_d  = word_idx_q;
      last_idx_d  = last_idx_q;
      shift_d     = shift_q;
      rom_we_d    = 1'b0;
      rom_addr_d  = rom_addr_q;
      rom_wdata_d = rom_wdata_q;

      unique case (state_q)
         ST_HDR: begin
            if (accept) begin
               shift_d    = {bus.in_data, shift_q[23:8]};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  if (word == 32'd0) begin
                     state_d = ST_FLUSH;
                  end else if (word > 32'(MAX_WORDS)) begin
                     state_d = ST_ERR;
                  end else begin
                     state_d    = ST_DATA;
                     word_idx_d = '0;
                     last_idx_d = ADDR_W'(word - 32'd1);
                  end
               end
            end
         end
         ST_DATA: begin
            if (accept) begin
               shift_d    = {bus.in_data, shift_q[23:8]};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  rom_we_d    = 1'b1;
                  rom_addr_d  = word_idx_q;
                  rom_wdata_d = word;
                  if (word_idx_q == last_idx_q) begin
                     state_d = ST_FLUSH;
                  end else begin
                     word_idx_d = word_idx_q + IDX_ONE;
                  end
               end
            end
         end
         ST_FLUSH: begin
            state_d = ST_DONE;
         end
         ST_DONE, ST_ERR: begin
            if (reload) begin
               state_d    = ST_HDR;
               byte_cnt_d = '0;
               word_idx_d = '0;
               last_idx_d = '0;
               shift_d    = '0;
            end
         end
         default: begin
            state_d = ST_HDR;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_HDR;
         byte_cnt_q  <= '0;
         word_idx_q  <= '0;
         last_idx_q  <= '0;
         shift_q     <= '0;
         rom_we_q    <= 1'b0;
         rom_addr_q  <= '0;
         rom_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         word_idx_q  <= word_idx_d;
         last_idx_q  <= last_idx_d;
         shift_q     <= shift_d;
         rom_we_q    <= rom_we_d;
         rom_addr_q  <= rom_addr_d;
         rom_wdata_q <= rom_wdata_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.rom_we    = rom_we_q;
   assign bus.rom_addr  = rom_addr_q;
   assign bus.rom_wdata = rom_wdata_q;

   assign load_busy = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_FLUSH);
   assign load_done = (state_q == ST_DONE);
   assign load_err  = (state_q == ST_ERR);
   assign core_hold = (state_q != ST_DONE);

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: directed frames plus random images against a
// queue-based model of the expected ROM writes.
module tb_rom_loader;

   localparam int ADDR_W    = 12;
   localparam int MAX_WORDS = 4096;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   logic reload;
   logic load_busy, load_done, load_err, core_hold;

   rom_loader_if #(.ADDR_W(ADDR_W)) bus ();

   rom_loader #(
      .ADDR_W   (ADDR_W),
      .MAX_WORDS(MAX_WORDS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.master),
      .reload   (reload),
      .load_busy(load_busy),
      .load_done(load_done),
      .load_err (load_err),
      .core_hold(core_hold)
   );

   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned timeouts = 0;
   int unsigned ready_drops = 0;

   logic [7:0]  frame_q[$];
   logic [31:0] words_q[$];
   wr_t         exp_q[$];
   wr_t         obs_q[$];

   always @(negedge clk) begin
      if (bus.rom_we === 1'b1) obs_q.push_back({bus.rom_addr, bus.rom_wdata});
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h required %0h", tag, obs, exp);
      end
   endtask

   // Model: header is N little-endian, then each word little-endian; a legal
   // N equal to the supplied word count yields writes addr i <- word i.
   task automatic make_frame(input logic [31:0] n);
      frame_q.delete();
      exp_q.delete();
      for (int b = 0; b < 4; b++) frame_q.push_back(8'((n >> (8 * b)) & 32'hFF));
      foreach (words_q[i]) begin
         for (int b = 0; b < 4; b++) frame_q.push_back(8'((words_q[i] >> (8 * b)) & 32'hFF));
      end
      if (n >= 1 && n <= MAX_WORDS && n == 32'(words_q.size())) begin
         foreach (words_q[i]) exp_q.push_back({ADDR_W'(i), words_q[i]});
      end
   endtask

   task automatic send(input int unsigned count, input int unsigned gmin, input int unsigned gmax);
      for (int i = 0; i < int'(count); i++) begin
         int unsigned g;
         int unsigned w;
         g = $urandom_range(gmax, gmin);
         for (int k = 0; k < int'(g); k++) begin
            bus.in_valid = 1'b0;
            if (bus.in_ready !== 1'b1) ready_drops++;
            step();
         end
         bus.in_valid = 1'b1;
         bus.in_data  = frame_q[i];
         w = 0;
         while (bus.in_ready !== 1'b1 && w < 20) begin
            step();
            w++;
         end
         if (w == 20) timeouts++;
         step();
      end
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
   endtask

   task automatic check_writes(input string tag);
      int unsigned n;
      chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < int'(n); i++) chk({tag, "_wr"}, 64'(obs_q[i]), 64'(exp_q[i]));
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      step();
      reload = 1'b0;
   endtask

   task automatic chk_done(input string tag);
      chk({tag, "_done"}, {62'd0, load_done, core_hold}, 64'b10);
      chk({tag, "_ready"}, 64'(bus.in_ready), 64'd0);
   endtask

   initial begin
      int unsigned acc;
      rst = 1'b1;
      reload = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = 8'h00;
      step();
      step();
      chk("rst_outs", {58'd0, bus.in_ready, bus.rom_we, load_busy, load_done, load_err, core_hold},
          64'b101001);
      chk("rst_addr_data", {20'd0, bus.rom_addr, bus.rom_wdata}, 64'd0);
      rst = 1'b0;
      step();

      // Directed two-word frame, one byte per cycle
      obs_q.delete();
      words_q.delete();
      words_q.push_back(32'hDEADBEEF);
      words_q.push_back(32'h12345678);
      make_frame(32'd2);
      send(frame_q.size(), 0, 0);
      chk("t1_flush_we", {20'd0, bus.rom_addr, bus.rom_wdata, 8'd0} | 64'(bus.rom_we),
          {20'd0, 12'd1, 32'h12345678, 8'd0} | 64'd1);
      chk("t1_flush_state", {60'd0, bus.in_ready, load_busy, load_done, core_hold}, 64'b0101);
      step();
      chk_done("t1");
      chk("t1_we_pulse", 64'(bus.rom_we), 64'd0);
      check_writes("t1");
      pulse_reload();

      // Same stream with in_valid toggling
      obs_q.delete();
      ready_drops = 0;
      send(frame_q.size(), 1, 1);
      chk("t2_ready_held", 64'(ready_drops), 64'd0);
      chk("t2_ready_flush", 64'(bus.in_ready), 64'd0);
      step();
      chk_done("t2");
      check_writes("t2");
      pulse_reload();

      // Empty image
      obs_q.delete();
      words_q.delete();
      make_frame(32'd0);
      send(4, 0, 0);
      chk("t3_flush", {62'd0, load_busy, load_done}, 64'b10);
      step();
      chk_done("t3");
      check_writes("t3");
      pulse_reload();

      // Oversized header
      obs_q.delete();
      make_frame(32'(MAX_WORDS + 1));
      send(4, 0, 0);
      step();
      chk("t4_err", {59'd0, load_err, core_hold, bus.in_ready, load_busy, load_done}, 64'b11000);
      chk("t4_nowr", 64'(obs_q.size()), 64'd0);
      pulse_reload();
      chk("t4_reload_hdr", {61'd0, load_err, bus.in_ready, core_hold}, 64'b011);
      words_q.delete();
      words_q.push_back($urandom);
      make_frame(32'd1);
      send(frame_q.size(), 0, 0);
      step();
      chk_done("t4b");
      check_writes("t4b");
      pulse_reload();

      // Reset mid-frame discards partial data
      obs_q.delete();
      words_q.delete();
      words_q.push_back($urandom);
      words_q.push_back($urandom);
      make_frame(32'd2);
      send(6, 0, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_nowr", 64'(obs_q.size()), 64'd0);
      chk("t5_hdr", {61'd0, bus.in_ready, load_busy, core_hold}, 64'b111);
      words_q.delete();
      words_q.push_back(32'h00000013);
      make_frame(32'd1);
      send(frame_q.size(), 0, 0);
      step();
      chk_done("t5");
      check_writes("t5");

      // Bytes offered in DONE are ignored; rst with reload lands in HDR
      obs_q.delete();
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data = 8'($urandom);
         if (bus.in_ready === 1'b1) acc++;
         step();
      end
      bus.in_valid = 1'b0;
      chk("t6_noaccept", 64'(acc), 64'd0);
      chk("t6_nowr", 64'(obs_q.size()), 64'd0);
      chk("t6_still_done", 64'(load_done), 64'd1);
      rst = 1'b1;
      reload = 1'b1;
      step();
      rst = 1'b0;
      reload = 1'b0;
      chk("t6_rst_reload", {59'd0, bus.in_ready, load_busy, load_done, core_hold, bus.rom_we},
          64'b11010);

      // Random images with random stalls
      for (int f = 0; f < 5; f++) begin
         int unsigned n;
         obs_q.delete();
         ready_drops = 0;
         words_q.delete();
         n = $urandom_range(6, 1);
         for (int i = 0; i < int'(n); i++) words_q.push_back($urandom);
         make_frame(32'(n));
         send(frame_q.size(), 0, 2);
         chk("rnd_ready_held", 64'(ready_drops), 64'd0);
         step();
         chk_done("rnd");
         check_writes("rnd");
         pulse_reload();
      end

      chk("timeouts", 64'(timeouts), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
